// File: rtl/converter_66b_to_64b_if.sv
// AXI-Stream style bundle (tdata/tvalid/tready) shared by the gearbox input and output sides.
// master drives data and valid, slave drives ready; width is set per instance.
interface converter_66b_to_64b_if #(
  parameter int unsigned DW = 64
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/converter_66b_to_64b.sv
// TX 66b->64b gearbox: 32 blocks become 33 line words, first bits out one cycle after accept.
// Backpressure: a stalled sink freezes everything; input is refused one cycle in 33 (phase 32).
module converter_66b_to_64b (
  input  logic                    clk,
  input  logic                    reset_n,
  converter_66b_to_64b_if.slave   s_axis,
  converter_66b_to_64b_if.master  m_axis
);

  localparam logic [5:0] LAST_PHASE = 6'd32;

  logic [5:0]   phase_q, phase_d;
  logic [63:0]  res_q, res_d;
  logic [63:0]  word_q, word_d;
  logic         vld_q, vld_d;

  logic         out_free;
  logic         last;
  logic         load;
  logic [6:0]   shamt;
  logic [129:0] window;
  logic [65:0]  keep_mask;

  // res is right-aligned with zeros above bit 2*phase-1, so {res, block} shifted
  // right by 2*phase+2 leaves the next 64 stream bits in the low word for every phase.
  always_comb begin
    out_free  = !vld_q || m_axis.tready;
    last      = (phase_q == LAST_PHASE);
    load      = out_free && (last || s_axis.tvalid);
    shamt     = {phase_q, 1'b0} + 7'd2;
    window    = {res_q, (last ? 66'd0 : s_axis.tdata)};
    keep_mask = (66'd1 << shamt) - 66'd1;

    phase_d = phase_q;
    res_d   = res_q;
    word_d  = word_q;
    vld_d   = vld_q && !m_axis.tready;

    if (load) begin
      word_d = 64'(window >> shamt);
      vld_d  = 1'b1;
      if (last) begin
        phase_d = 6'd0;
        res_d   = 64'd0;
      end else begin
        phase_d = phase_q + 6'd1;
        res_d   = 64'(s_axis.tdata & keep_mask);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 6'd0;
      res_q   <= 64'd0;
      word_q  <= 64'd0;
      vld_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      res_q   <= res_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
    end
  end

  // Ready is gated by reset_n so it is low for the whole time reset is held.
  assign s_axis.tready = reset_n && out_free && !last;
  assign m_axis.tdata  = word_q;
  assign m_axis.tvalid = vld_q;

endmodule

// File: tb/tb_converter_66b_to_64b.sv
// Directed vectors plus a bit-stream scoreboard and 66-bit regrouping for the gearbox.
module tb_converter_66b_to_64b;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  converter_66b_to_64b_if #(.DW(66)) s_if ();
  converter_66b_to_64b_if #(.DW(64)) m_if ();

  converter_66b_to_64b dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_axis  (s_if),
    .m_axis  (m_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [65:0] blk;
    logic [63:0] word;
  } vec_t;
  vec_t vecs[6];

  logic [65:0] src_q[$];
  logic [65:0] sent_q[$];
  bit          exp_bits[$];
  bit          rx_bits[$];
  logic [63:0] exp_words[$];
  logic [63:0] got_words[$];
  int          low_cycles[$];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [65:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %h, required nothing", name, act);
  endtask

  function automatic logic [65:0] rnd_blk();
    return {2'($urandom_range(3)), 32'($urandom), 32'($urandom)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n     = 1'b0;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    m_if.tready = 1'b1;
    src_q.delete(); sent_q.delete(); exp_bits.delete(); rx_bits.delete();
    exp_words.delete(); got_words.delete(); low_cycles.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drives src_q with random source gaps and sink stalls; checks every word against
  // the ideal MSB-first packing and regroups the output into 66-bit blocks.
  task automatic run_stream(input int p_src, input int p_sink, input int budget);
    int          idx = 0;
    int          cyc = 0;
    bit          pend = 0;
    bit          hold_vld = 0;
    logic [63:0] hold_dat = '0;
    int          stab_err = 0;
    bit          done = 0;
    logic [63:0] w;
    logic [65:0] b;
    while (!done) begin
      @(negedge clk);
      if (!pend) begin
        if (idx < src_q.size() && $urandom_range(99) < p_src) begin
          s_if.tvalid = 1'b1;
          s_if.tdata  = src_q[idx];
        end else begin
          s_if.tvalid = 1'b0;
        end
      end
      m_if.tready = ($urandom_range(99) < p_sink);
      #1;
      if (!s_if.tready && m_if.tready) low_cycles.push_back(cyc);
      if (hold_vld && (!m_if.tvalid || m_if.tdata !== hold_dat)) stab_err++;
      hold_vld = m_if.tvalid && !m_if.tready;
      hold_dat = m_if.tdata;
      if (s_if.tvalid && s_if.tready) begin
        for (int k = 65; k >= 0; k--) exp_bits.push_back(s_if.tdata[k]);
        while (exp_bits.size() >= 64) begin
          for (int k = 63; k >= 0; k--) w[k] = exp_bits.pop_front();
          exp_words.push_back(w);
        end
        sent_q.push_back(s_if.tdata);
        idx++;
        pend = 1'b0;
      end else begin
        pend = s_if.tvalid;
      end
      if (m_if.tvalid && m_if.tready) begin
        got_words.push_back(m_if.tdata);
        if (exp_words.size() == 0) fail_now("extra_word", 66'(m_if.tdata));
        else chk("word", 66'(m_if.tdata), 66'(exp_words.pop_front()));
        for (int k = 63; k >= 0; k--) rx_bits.push_back(m_if.tdata[k]);
        while (rx_bits.size() >= 66) begin
          for (int k = 65; k >= 0; k--) b[k] = rx_bits.pop_front();
          if (sent_q.size() == 0) fail_now("loopback_extra", b);
          else chk("loopback_blk", b, sent_q.pop_front());
        end
      end
      cyc++;
      @(posedge clk);
      if (idx == src_q.size() && exp_words.size() == 0 && !pend) done = 1'b1;
      else if (cyc >= budget) begin
        fail_now("stream_timeout", 66'(cyc));
        done = 1'b1;
      end
    end
    @(negedge clk);
    s_if.tvalid = 1'b0;
    chk("stall_hold", 66'(stab_err), 66'd0);
    chk("residual_bits", 66'(exp_bits.size()), 66'd0);
    chk("unrecovered_blks", 66'(sent_q.size()), 66'd0);
  endtask

  initial begin
    vecs[0] = '{66'h1_0123_4567_89AB_CDEF, 64'h4048_D159_E26A_F37B};
    vecs[1] = '{66'h0,                     64'hC000_0000_0000_0000};
    vecs[2] = '{66'h3_FFFF_FFFF_FFFF_FFFF, 64'h0FFF_FFFF_FFFF_FFFF};
    vecs[3] = '{66'h0,                     64'hFC00_0000_0000_0000};
    vecs[4] = '{66'h2_AAAA_AAAA_AAAA_AAAA, 64'h00AA_AAAA_AAAA_AAAA};
    vecs[5] = '{66'h0,                     64'hAA80_0000_0000_0000};

    // Reset state, with a valid block offered during reset.
    reset_n     = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 66'h2_1234_5678_9ABC_DEF0;
    m_if.tready = 1'b1;
    #1;
    chk("rst_tvalid", 66'(m_if.tvalid), 66'd0);
    chk("rst_tdata", 66'(m_if.tdata), 66'd0);
    chk("rst_tready", 66'(s_if.tready), 66'd0);
    @(posedge clk); #1;
    chk("rst_tready_held", 66'(s_if.tready), 66'd0);
    chk("rst_tvalid_held", 66'(m_if.tvalid), 66'd0);
    @(negedge clk);
    reset_n     = 1'b1;
    s_if.tvalid = 1'b0;
    #1;
    chk("ready_after_rst", 66'(s_if.tready), 66'd1);

    // Table: back-to-back blocks, sink always ready, one-cycle latency.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_if.tvalid = 1'b1;
      s_if.tdata  = vecs[i].blk;
      #1;
      chk("tbl_tready", 66'(s_if.tready), 66'd1);
      @(posedge clk); #1;
      chk("tbl_tvalid", 66'(m_if.tvalid), 66'd1);
      chk("tbl_word", 66'(m_if.tdata), 66'(vecs[i].word));
    end

    // Sink stall: ready drops, word frozen; then a source gap drains tvalid.
    @(negedge clk);
    s_if.tvalid = 1'b0;
    m_if.tready = 1'b0;
    #1;
    chk("bp_tready", 66'(s_if.tready), 66'd0);
    @(posedge clk); #1;
    chk("bp_tdata_hold", 66'(m_if.tdata), 66'h0_AA80_0000_0000_0000);
    chk("bp_tvalid_hold", 66'(m_if.tvalid), 66'd1);
    @(negedge clk);
    m_if.tready = 1'b1;
    #1;
    chk("gap_tready", 66'(s_if.tready), 66'd1);
    @(posedge clk); #1;
    chk("gap_tvalid_drop", 66'(m_if.tvalid), 66'd0);

    // Reset in the middle of a 33-word cycle (phase 17).
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      s_if.tvalid = 1'b1;
      s_if.tdata  = rnd_blk();
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    chk("mid_pre_tvalid", 66'(m_if.tvalid), 66'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 66'(m_if.tvalid), 66'd0);
    chk("mid_rst_tready", 66'(s_if.tready), 66'd0);
    chk("mid_rst_tdata", 66'(m_if.tdata), 66'd0);
    @(negedge clk);
    reset_n    = 1'b1;
    s_if.tdata = 66'h3_FFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    chk("post_rst_w0", 66'(m_if.tdata), 66'h0_FFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    s_if.tdata = 66'h0;
    @(posedge clk); #1;
    chk("post_rst_w1", 66'(m_if.tdata), 66'h0_C000_0000_0000_0000);
    @(negedge clk);
    s_if.tvalid = 1'b0;

    // Two full 32-block cycles, continuous source and sink.
    do_reset();
    for (int i = 0; i < 64; i++) src_q.push_back({2'b01, 64'(i % 32)});
    run_stream(100, 100, 500);
    chk("full_word_count", 66'(got_words.size()), 66'd66);
    if (got_words.size() == 66) begin
      chk("full_w0", 66'(got_words[0]), 66'h0_4000_0000_0000_0000);
      chk("full_w32", 66'(got_words[32]), 66'h1F);
      chk("full_w65", 66'(got_words[65]), 66'h1F);
    end
    chk("full_rdy_low_count", 66'(low_cycles.size()), 66'd2);
    if (low_cycles.size() == 2) begin
      chk("full_rdy_low_0", 66'(low_cycles[0]), 66'd32);
      chk("full_rdy_low_1", 66'(low_cycles[1]), 66'd65);
    end

    // Random source gaps and 50% sink backpressure.
    do_reset();
    for (int i = 0; i < 3200; i++) src_q.push_back(rnd_blk());
    run_stream(70, 50, 20000);
    chk("bp_word_count", 66'(got_words.size()), 66'd3300);

    // Long random run regrouped back into blocks (padded to a whole 32-block cycle).
    do_reset();
    for (int i = 0; i < 10016; i++) src_q.push_back(rnd_blk());
    run_stream(90, 75, 40000);
    chk("loop_word_count", 66'(got_words.size()), 66'd10329);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
